// File: rtl/byte_serial_lsu.sv
// Byte-serial load/store unit: one 64-bit request becomes 1/2/4/8 single-byte memory accesses.
// Optional build macro LSU_MISALIGN_TRAP_EN turns addr % N != 0 into an error response.
module byte_serial_lsu #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_WData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [7:0]        Mem_RData
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  logic [XLEN-1:0]   wbuf;
  logic [XLEN-1:0]   rbuf;
  logic [1:0]        size;
  logic [2:0]        cnt;
  logic              sign;
  logic              wr;
  logic              err;

  logic              accept;
  logic              illegal;
  logic [2:0]        last_idx;
  logic [2:0]        req_mask;
  logic [XLEN-1:0]   ext_data;

  // Handshake: a request transfers on a posedge where req_valid and req_ready are both
  // high; req_ready is high only in IDLE, so at most one request is in flight.
  assign accept = req_valid & req_ready;

  always_comb begin
    req_mask = 3'b000;
    case (funct3[1:0])
      2'd0:    req_mask = 3'b000;
      2'd1:    req_mask = 3'b001;
      2'd2:    req_mask = 3'b011;
      default: req_mask = 3'b111;
    endcase
  end

  always_comb begin
    illegal = (funct3 == 3'b111) || (req_write && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr[2:0] & req_mask) != 3'b000) illegal = 1'b1;
`endif
  end

  always_comb begin
    last_idx = 3'd0;
    case (size)
      2'd0:    last_idx = 3'd0;
      2'd1:    last_idx = 3'd1;
      2'd2:    last_idx = 3'd3;
      default: last_idx = 3'd7;
    endcase
  end

  // Extension source is bit 8N-1 of the assembled bytes; zero when unsigned.
  always_comb begin
    ext_data = '0;
    case (size)
      2'd0:    ext_data = {{56{sign & rbuf[7]}},  rbuf[7:0]};
      2'd1:    ext_data = {{48{sign & rbuf[15]}}, rbuf[15:0]};
      2'd2:    ext_data = {{32{sign & rbuf[31]}}, rbuf[31:0]};
      default: ext_data = rbuf;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    Mem_Addr   = '0;
    Mem_WData  = 8'h00;
    MemWrite   = 1'b0;
    MemRead    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = illegal ? RESP : XFER;
      end
      XFER: begin
        Mem_Addr  = base + ADDR_W'(cnt);
        MemWrite  = wr;
        MemRead   = ~wr;
        Mem_WData = wr ? wbuf[{cnt, 3'b000} +: 8] : 8'h00;
        if (cnt == last_idx) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err;
        resp_rdata = (err || wr) ? '0 : ext_data;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      base  <= '0;
      wbuf  <= '0;
      rbuf  <= '0;
      size  <= 2'd0;
      cnt   <= 3'd0;
      sign  <= 1'b0;
      wr    <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            base <= addr;
            wbuf <= wdata;
            size <= funct3[1:0];
            sign <= ~funct3[2];
            wr   <= req_write;
            err  <= illegal;
            cnt  <= 3'd0;
            rbuf <= '0;
          end
        end
        XFER: begin
          if (!wr) rbuf[{cnt, 3'b000} +: 8] <= Mem_RData;
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_lsu.sv
// Directed bench for byte_serial_lsu with a 64-byte memory model and strobe monitor.
// Build with LSU_MISALIGN_TRAP_EN defined to expect misaligned accesses to be rejected.
module tb_byte_serial_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] Mem_Addr;
  logic [7:0]  Mem_WData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  Mem_RData;

  logic [7:0]  mem [0:63];
  int          n_checks;
  int          n_pass;
  int          rd_strobes;
  int          wr_strobes;
  int          both_strobes;
  logic [63:0] addr_q[$];

  byte_serial_lsu #(.ADDR_W(64), .XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .Mem_Addr  (Mem_Addr),
    .Mem_WData (Mem_WData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Mem_RData (Mem_RData)
  );

  // clock / memory model / monitor
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Mem_RData = mem[Mem_Addr[5:0]];

  always @(posedge clk) begin
    if (MemWrite) mem[Mem_Addr[5:0]] <= Mem_WData;
  end

  always @(negedge clk) begin
    if (MemRead) rd_strobes++;
    if (MemWrite) wr_strobes++;
    if (MemRead && MemWrite) both_strobes++;
    if (MemRead || MemWrite) addr_q.push_back(Mem_Addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issues one request from an IDLE cycle and waits (bounded) for the response.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output logic [63:0] rd,
                         output logic er, output int lat);
    rd_strobes = 0;
    wr_strobes = 0;
    both_strobes = 0;
    addr_q.delete();
    req_valid = 1'b1;
    req_write = w;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    funct3    = 3'b111;
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'd1);
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk);
    #1;
    check("resp_one_cycle", 64'(resp_valid), 64'd0);
    check("ready_after", 64'(req_ready), 64'd1);
    check("both_strobes", 64'(both_strobes), 64'd0);
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] exp, input int n);
    logic [63:0] rd;
    logic er;
    int lat;
    run_req(1'b0, f3, a, 64'h0, rd, er, lat);
    check({tag, "_rdata"}, rd, exp);
    check({tag, "_err"}, 64'(er), 64'd0);
    check({tag, "_lat"}, 64'(lat), 64'(n));
    check({tag, "_reads"}, 64'(rd_strobes), 64'(n));
    check({tag, "_writes"}, 64'(wr_strobes), 64'd0);
  endtask

  task automatic store_chk(input string tag, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int n);
    logic [63:0] rd;
    logic er;
    int lat;
    run_req(1'b1, f3, a, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, 64'd0);
    check({tag, "_err"}, 64'(er), 64'd0);
    check({tag, "_lat"}, 64'(lat), 64'(n));
    check({tag, "_writes"}, 64'(wr_strobes), 64'(n));
    check({tag, "_reads"}, 64'(rd_strobes), 64'd0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
    logic [63:0] rd;
    logic er;
    int lat;
    run_req(w, f3, a, wd, rd, er, lat);
    check({tag, "_rdata"}, rd, 64'd0);
    check({tag, "_err"}, 64'(er), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd0);
    check({tag, "_strobes"}, 64'(rd_strobes + wr_strobes), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    rd_strobes = 0;
    wr_strobes = 0;
    both_strobes = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'hAC;
    mem[63] = 8'h12;
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    funct3 = 3'b000;
    addr = 64'h0;
    wdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    check("rst_mem_addr", Mem_Addr, 64'd0);
    check("rst_mem_wdata", 64'(Mem_WData), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    load_chk("ld0", 3'b011, 64'd0, 64'h0000_0000_0000_00AC, 8);
    load_chk("lb0", 3'b000, 64'd0, 64'hFFFF_FFFF_FFFF_FFAC, 1);
    load_chk("lbu0", 3'b100, 64'd0, 64'h0000_0000_0000_00AC, 1);

    store_chk("sd16", 3'b011, 64'd16, 64'h1122_3344_5566_7788, 8);
    check("sd16_b16", 64'(mem[16]), 64'h88);
    check("sd16_b23", 64'(mem[23]), 64'h11);
    load_chk("ld16", 3'b011, 64'd16, 64'h1122_3344_5566_7788, 8);
    load_chk("lw16", 3'b010, 64'd16, 64'h0000_0000_5566_7788, 4);
    load_chk("lw20", 3'b010, 64'd20, 64'h0000_0000_1122_3344, 4);
    load_chk("lh22", 3'b001, 64'd22, 64'h0000_0000_0000_1122, 2);
    load_chk("lhu20", 3'b101, 64'd20, 64'h0000_0000_0000_3344, 2);
    load_chk("lb16", 3'b000, 64'd16, 64'hFFFF_FFFF_FFFF_FF88, 1);

    store_chk("sw40", 3'b010, 64'd40, 64'hCAFE_0000_DEAD_BEEF, 4);
    check("sw40_b44", 64'(mem[44]), 64'h00);
    load_chk("lw40", 3'b010, 64'd40, 64'hFFFF_FFFF_DEAD_BEEF, 4);
    load_chk("lwu40", 3'b110, 64'd40, 64'h0000_0000_DEAD_BEEF, 4);
    load_chk("lh40", 3'b001, 64'd40, 64'hFFFF_FFFF_FFFF_BEEF, 2);
    load_chk("lhu42", 3'b101, 64'd42, 64'h0000_0000_0000_DEAD, 2);

`ifdef LSU_MISALIGN_TRAP_EN
    err_chk("sh3_trap", 1'b1, 3'b001, 64'd3, 64'h0000_0000_0000_BEEF);
    check("sh3_trap_b3", 64'(mem[3]), 64'h00);
    check("sh3_trap_b4", 64'(mem[4]), 64'h00);
    err_chk("lh_wrap_trap", 1'b0, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
`else
    store_chk("sh3", 3'b001, 64'd3, 64'h0000_0000_0000_BEEF, 2);
    check("sh3_b3", 64'(mem[3]), 64'hEF);
    check("sh3_b4", 64'(mem[4]), 64'hBE);
    load_chk("lh_wrap", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_AC12, 2);
    check("wrap_addr0", (addr_q.size() > 0) ? addr_q[0] : 64'hx, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wrap_addr1", (addr_q.size() > 1) ? addr_q[1] : 64'hx, 64'h0);
`endif

    err_chk("f3_111_load", 1'b0, 3'b111, 64'd0, 64'h0);
    err_chk("store_f3_100", 1'b1, 3'b100, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    check("store_f3_100_b8", 64'(mem[8]), 64'h00);

    // reset lands on the edge that writes the third byte of a doubleword store
    for (int i = 32; i < 40; i++) mem[i] = 8'h55;
    req_valid = 1'b1;
    req_write = 1'b1;
    funct3    = 3'b011;
    addr      = 64'd32;
    wdata     = 64'hA1A2_A3A4_A5A6_A7A8;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rstx_ready", 64'(req_ready), 64'd1);
    check("rstx_resp_valid", 64'(resp_valid), 64'd0);
    check("rstx_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("rstx_b32", 64'(mem[32]), 64'hA8);
    check("rstx_b33", 64'(mem[33]), 64'hA7);
    check("rstx_b34", 64'(mem[34]), 64'hA6);
    for (int i = 35; i < 40; i++) check($sformatf("rstx_b%0d", i), 64'(mem[i]), 64'h55);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rstx_no_resp", 64'(resp_valid), 64'd0);
    end
    check("rstx_idle_ready", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
